// File: rtl/ds18b20_pkg.sv
// Shared types and constants for the DS18B20 1-Wire slave emulator.
package ds18b20_pkg;

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES_LOW, ROM_CMD, FUNC_CMD, CONV_POLL, TX_SCRATCH, DONE
  } state_t;

  localparam logic [7:0]  CMD_SKIP_ROM     = 8'hCC;
  localparam logic [7:0]  CMD_CONVERT_T    = 8'h44;
  localparam logic [7:0]  CMD_READ_SCRATCH = 8'hBE;

  localparam logic [7:0]  SP_TH  = 8'hFF;
  localparam logic [7:0]  SP_TL  = 8'hFF;
  localparam logic [7:0]  SP_CFG = 8'h1F;

  localparam logic [15:0] POWERON_TEMP = 16'h0550;

  // Scratchpad byte 0..7 for a given temperature (byte 8 is the CRC, supplied elsewhere).
  function automatic logic [7:0] sp_byte(input logic [3:0] idx, input logic [15:0] temp);
    case (idx)
      4'd0:    sp_byte = temp[7:0];
      4'd1:    sp_byte = temp[15:8];
      4'd2:    sp_byte = SP_TH;
      4'd3:    sp_byte = SP_TL;
      4'd4:    sp_byte = SP_CFG;
      default: sp_byte = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ds18b20_slave_crc.sv
// Serial Dallas/Maxim CRC8 (reflected 0x8C) with clear, update and plain shift-out.
module ow_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       shift,
  input  logic       bit_in,
  output logic [7:0] crc
);

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic [7:0] n;
    n = {1'b0, c[7:1]};
    if (c[0] ^ b) n = n ^ 8'h8C;
    return n;
  endfunction

  // CRC register: clear wins, then data update, then shift-out of the finished value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       crc <= 8'h00;
    else if (clr)   crc <= 8'h00;
    else if (en)    crc <= crc_step(crc, bit_in);
    else if (shift) crc <= {1'b0, crc[7:1]};
  end

endmodule

// File: rtl/ds18b20_slave.sv
// DS18B20 responder: presence, Skip ROM, Convert-T polling and scratchpad read on open-drain DQ.
module ds18b20_slave
  import ds18b20_pkg::*;
#(
  parameter int CLK_MHZ      = 27,
  parameter int RESET_MIN_US = 480,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_LOW_US  = 120,
  parameter int SAMPLE_US    = 30,
  parameter int ZERO_HOLD_US = 45,
  parameter int CONV_US      = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_i,
  output logic        dq_oe,
  input  logic [15:0] temp_in,
  output logic        conv_busy,
  output logic        cmd_strobe,
  output logic [7:0]  cmd,
  output logic        cmd_err
);

  localparam int PRE_W  = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int CONV_W = $clog2(CONV_US + 1);

  state_t            state;
  logic              dq_p0, dq_p1, dq_p2;
  logic [PRE_W-1:0]  pre_cnt;
  logic [15:0]       low_us, us_cnt;
  logic [CONV_W-1:0] conv_cnt;
  logic [15:0]       sp_temp, tx_temp;
  logic [7:0]        rx_sr, rx_next, tx_byte, crc;
  logic [2:0]        bit_cnt;
  logic [6:0]        bit_idx;
  logic              slot_act;
  logic              tick, fall, rise, bus_rst, slot_fall, pres_start;
  logic              samp, byte_done, conv_start, conv_end, poll_bit, tx_bit;
  logic              crc_clr, crc_en, crc_shift;

  // Two-flop synchronizer plus one history flop for edge detection; bus idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dq_p0 <= 1'b1;
      dq_p1 <= 1'b1;
      dq_p2 <= 1'b1;
    end else begin
      dq_p0 <= dq_i;
      dq_p1 <= dq_p0;
      dq_p2 <= dq_p1;
    end
  end

  // Free-running microsecond prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  always_comb begin
    tick       = (pre_cnt == PRE_W'(CLK_MHZ - 1));
    fall       = dq_p2 & ~dq_p1;
    rise       = ~dq_p2 & dq_p1;
    bus_rst    = rise && (low_us >= 16'(RESET_MIN_US));
    slot_fall  = fall && !dq_oe && !bus_rst;
    pres_start = (state == PRES_WAIT) && (us_cnt == 16'(PRES_WAIT_US));
    samp       = slot_act && (us_cnt == 16'(SAMPLE_US)) && !bus_rst &&
                 ((state == ROM_CMD) || (state == FUNC_CMD));
    rx_next    = {dq_p1, rx_sr[7:1]};
    byte_done  = samp && (bit_cnt == 3'd7);
    conv_start = (state == FUNC_CMD) && byte_done && (rx_next == CMD_CONVERT_T);
    conv_end   = conv_busy && tick && (conv_cnt == CONV_W'(1));
    poll_bit   = !conv_busy || conv_end;
    tx_byte    = sp_byte(bit_idx[6:3], tx_temp);
    tx_bit     = bit_idx[6] ? crc[0] : tx_byte[bit_idx[2:0]];
    crc_clr    = (state == FUNC_CMD) && byte_done && (rx_next == CMD_READ_SCRATCH);
    crc_en     = (state == TX_SCRATCH) && slot_fall && !bit_idx[6];
    crc_shift  = (state == TX_SCRATCH) && slot_fall && bit_idx[6];
  end

  // Low-time measurement, saturating at the reset threshold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                   low_us <= '0;
    else if (fall)                                              low_us <= '0;
    else if (!dq_p1 && tick && (low_us < 16'(RESET_MIN_US)))    low_us <= low_us + 16'd1;
  end

  // Slot / phase timer in microseconds, restarted at each slot and presence phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  us_cnt <= '0;
    else if (bus_rst || slot_fall || pres_start) us_cnt <= '0;
    else if (tick && (us_cnt != 16'hFFFF))     us_cnt <= us_cnt + 16'd1;
  end

  // Conversion timer and scratchpad temperature; a bus reset does not stop it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_busy <= 1'b0;
      conv_cnt  <= '0;
      sp_temp   <= POWERON_TEMP;
    end else if (conv_start && !bus_rst) begin
      conv_busy <= 1'b1;
      conv_cnt  <= CONV_W'(CONV_US);
    end else if (conv_end) begin
      conv_busy <= 1'b0;
      sp_temp   <= temp_in;
    end else if (conv_busy && tick) begin
      conv_cnt  <= conv_cnt - CONV_W'(1);
    end
  end

  ow_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr && !bus_rst),
    .en     (crc_en),
    .shift  (crc_shift),
    .bit_in (tx_bit),
    .crc    (crc)
  );

  // Protocol FSM with registered bus drive and command pulses; bus reset has top priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dq_oe      <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd        <= 8'h00;
      cmd_err    <= 1'b0;
      slot_act   <= 1'b0;
      rx_sr      <= 8'h00;
      bit_cnt    <= 3'd0;
      bit_idx    <= 7'd0;
      tx_temp    <= POWERON_TEMP;
    end else begin
      cmd_strobe <= 1'b0;
      cmd_err    <= 1'b0;
      if (dq_oe && (state != PRES_LOW) && (us_cnt >= 16'(ZERO_HOLD_US))) dq_oe <= 1'b0;
      if (bus_rst) begin
        state    <= PRES_WAIT;
        dq_oe    <= 1'b0;
        slot_act <= 1'b0;
        rx_sr    <= 8'h00;
        bit_cnt  <= 3'd0;
        bit_idx  <= 7'd0;
      end else begin
        case (state)
          PRES_WAIT: if (pres_start) begin
            dq_oe <= 1'b1;
            state <= PRES_LOW;
          end
          PRES_LOW: if (us_cnt >= 16'(PRES_LOW_US)) begin
            dq_oe <= 1'b0;
            state <= ROM_CMD;
          end
          ROM_CMD, FUNC_CMD: begin
            if (slot_fall) slot_act <= 1'b1;
            else if (samp) begin
              slot_act <= 1'b0;
              rx_sr    <= rx_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (state == ROM_CMD) begin
                  if (rx_next == CMD_SKIP_ROM) state <= FUNC_CMD;
                  else begin
                    cmd_err <= 1'b1;
                    state   <= DONE;
                  end
                end else begin
                  cmd_strobe <= 1'b1;
                  cmd        <= rx_next;
                  if (rx_next == CMD_CONVERT_T) state <= CONV_POLL;
                  else if (rx_next == CMD_READ_SCRATCH) begin
                    state   <= TX_SCRATCH;
                    bit_idx <= 7'd0;
                    tx_temp <= sp_temp;
                  end else begin
                    cmd_err <= 1'b1;
                    state   <= DONE;
                  end
                end
              end
            end
          end
          CONV_POLL: if (slot_fall && !poll_bit) dq_oe <= 1'b1;
          TX_SCRATCH: if (slot_fall) begin
            if (!tx_bit) dq_oe <= 1'b1;
            bit_idx <= bit_idx + 7'd1;
            if (bit_idx == 7'd71) state <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_slave.sv
// Directed bench for ds18b20_slave acting as a 1-Wire master on a wired-AND bus.
`timescale 1ns/1ps
module tb_ds18b20_slave;
  import ds18b20_pkg::*;

  localparam int CLK_MHZ = 2;
  localparam int US      = 10 * CLK_MHZ;   // ns per microsecond with a 10 ns clock

  logic        clk = 1'b0;
  logic        rst, m_low, dq_i, dq_oe, conv_busy, cmd_strobe, cmd_err;
  logic [15:0] temp_in;
  logic [7:0]  cmd;
  logic [7:0]  rb [0:8];

  int checks = 0, failures = 0, n_err = 0, n_stb = 0;

  typedef struct {
    logic [7:0] rom;
    logic [7:0] fn;
    logic       send_fn;
    int         exp_err;
    int         exp_stb;
    logic [7:0] exp_cmd;
    logic       quiet;
  } vec_t;
  vec_t tbl [0:2];

  always #5 clk = ~clk;
  assign dq_i = ~(m_low | dq_oe);

  ds18b20_slave #(.CLK_MHZ(CLK_MHZ), .CONV_US(1000)) dut (
    .clk(clk), .rst(rst), .dq_i(dq_i), .dq_oe(dq_oe), .temp_in(temp_in),
    .conv_busy(conv_busy), .cmd_strobe(cmd_strobe), .cmd(cmd), .cmd_err(cmd_err)
  );

  always @(negedge clk) begin
    if (cmd_err)    n_err++;
    if (cmd_strobe) n_stb++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    return c;
  endfunction

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    #((b ? 5 : 58) * US);
    m_low = 1'b0;
    #((b ? 58 : 5) * US);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    #(3 * US);
    m_low = 1'b0;
    #(12 * US);
    b = dq_i;
    #(48 * US);
  endtask

  task automatic read_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      read_bit(b);
      rb[i / 8][i % 8] = b;
    end
  endtask

  // 500 us reset pulse; returns presence delay and width in clock cycles (-1 on timeout)
  task automatic bus_reset(output int dly, output int wid);
    m_low = 1'b1;
    #(500 * US);
    m_low = 1'b0;
    dly = -1;
    wid = -1;
    for (int c = 0; c < 100 * CLK_MHZ; c++) begin
      @(negedge clk);
      if (dq_oe) begin dly = c; break; end
    end
    if (dly >= 0) begin
      for (int c = 1; c < 300 * CLK_MHZ; c++) begin
        @(negedge clk);
        if (!dq_oe) begin wid = c; break; end
      end
    end
    #(10 * US);
  endtask

  task automatic chk_scratch(input logic [15:0] t, input string tag);
    logic [7:0] exp [0:8];
    logic [7:0] c;
    exp[0] = t[7:0];  exp[1] = t[15:8]; exp[2] = 8'hFF; exp[3] = 8'hFF;
    exp[4] = 8'h1F;   exp[5] = 8'hFF;   exp[6] = 8'hFF; exp[7] = 8'hFF;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c = crc_upd(c, exp[i]);
    exp[8] = c;
    for (int i = 0; i < 9; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(rb[i]), 32'(exp[i]));
    c = 8'h00;
    for (int i = 0; i < 9; i++) c = crc_upd(c, rb[i]);
    chk({tag, "_crc_residue"}, 32'(c), 32'h0);
  endtask

  initial begin
    int   dly, wid, e0, s0, zeros;
    logic b;

    tbl[0] = '{rom:8'hCC, fn:8'hBE, send_fn:1'b1, exp_err:0, exp_stb:1, exp_cmd:8'hBE, quiet:1'b0};
    tbl[1] = '{rom:8'h33, fn:8'h00, send_fn:1'b0, exp_err:1, exp_stb:0, exp_cmd:8'hBE, quiet:1'b1};
    tbl[2] = '{rom:8'hCC, fn:8'hA5, send_fn:1'b1, exp_err:1, exp_stb:1, exp_cmd:8'hA5, quiet:1'b1};

    rst = 1'b0; m_low = 1'b0; temp_in = 16'h0000;
    repeat (5) @(negedge clk);
    chk("rst_dq_oe", 32'(dq_oe), 0);
    chk("rst_conv_busy", 32'(conv_busy), 0);
    chk("rst_cmd_strobe", 32'(cmd_strobe), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Short low pulse is not a reset
    m_low = 1'b1;
    #(300 * US);
    m_low = 1'b0;
    b = 1'b0;
    for (int c = 0; c < 200 * CLK_MHZ; c++) begin
      @(negedge clk);
      if (dq_oe) b = 1'b1;
    end
    chk("short_low_no_presence", 32'(b), 0);
    chk("short_low_state", 32'(dut.state), 32'(IDLE));

    // Proper reset and presence
    bus_reset(dly, wid);
    chk_rng("presence_delay_cycles", dly, 2 * 30 - 2, 2 * 30 + 6);
    chk_rng("presence_width_cycles", wid, 2 * 120 - 4, 2 * 120 + 6);
    chk("after_presence_state", 32'(dut.state), 32'(ROM_CMD));

    // Power-on scratchpad
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(72);
    chk_scratch(16'h0550, "poweron");

    // Command table
    for (int k = 0; k < 3; k++) begin
      bus_reset(dly, wid);
      e0 = n_err; s0 = n_stb;
      write_byte(tbl[k].rom);
      if (tbl[k].send_fn) write_byte(tbl[k].fn);
      chk($sformatf("tbl%0d_err_pulses", k), 32'(n_err - e0), 32'(tbl[k].exp_err));
      chk($sformatf("tbl%0d_strobe_pulses", k), 32'(n_stb - s0), 32'(tbl[k].exp_stb));
      chk($sformatf("tbl%0d_cmd", k), 32'(cmd), 32'(tbl[k].exp_cmd));
      if (tbl[k].quiet) begin
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
          read_bit(b);
          if (!b) zeros++;
        end
        chk($sformatf("tbl%0d_done_quiet", k), 32'(zeros), 0);
      end else begin
        read_bits(8);
        chk($sformatf("tbl%0d_byte0", k), 32'(rb[0]), 32'h50);
      end
    end

    // Conversion with polling
    temp_in = 16'hFC90;
    bus_reset(dly, wid);
    s0 = n_stb;
    write_byte(8'hCC);
    write_byte(8'h44);
    chk("conv_strobe", 32'(n_stb - s0), 1);
    chk("conv_cmd", 32'(cmd), 32'h44);
    chk("conv_busy_start", 32'(conv_busy), 1);
    #(18 * US);
    for (int k = 0; k < 12; k++) begin
      read_bit(b);
      chk($sformatf("poll%0d", k), 32'(b), (k < 10) ? 32'h0 : 32'h1);
      #(37 * US);
    end
    chk("conv_busy_end", 32'(conv_busy), 0);
    temp_in = 16'h1234;
    bus_reset(dly, wid);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(72);
    chk_scratch(16'hFC90, "converted");

    // Reset in the middle of a scratchpad read
    bus_reset(dly, wid);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(20);
    bus_reset(dly, wid);
    chk_rng("abort_presence_delay", dly, 2 * 30 - 2, 2 * 30 + 6);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(72);
    chk_scratch(16'hFC90, "restart");

    // Hardware reset during a conversion restores power-on scratchpad
    bus_reset(dly, wid);
    write_byte(8'hCC);
    write_byte(8'h44);
    chk("midrst_busy_before", 32'(conv_busy), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy_after", 32'(conv_busy), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus_reset(dly, wid);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_bits(16);
    chk("midrst_byte0", 32'(rb[0]), 32'h50);
    chk("midrst_byte1", 32'(rb[1]), 32'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
